// File: rtl/cprv_decode_stage_if.sv
// RV64I decode-stage bus: IF request, regfile read/write-back and EX pipeline register.
// No logic; pure signal bundle, latency defined by the stage that uses it.
// Backpressure via valid/ready pairs on both the IF side and the EX side.
interface cprv_decode_stage_if #(
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 64,
    parameter int IMM_WIDTH   = 64
);
    // IF side
    logic                   valid_id_i;
    logic                   ready_id_o;
    logic [INSTR_WIDTH-1:0] instr_data_id_i;
    logic [ADDR_WIDTH-1:0]  pc_id_i;
    logic                   flush_i;
    // register file read / write-back
    logic [4:0]             rs1_addr_wb_o;
    logic [4:0]             rs2_addr_wb_o;
    logic [DATA_WIDTH-1:0]  rs1_data_wb_i;
    logic [DATA_WIDTH-1:0]  rs2_data_wb_i;
    logic                   wb_en_i;
    logic [4:0]             wb_addr_i;
    logic [DATA_WIDTH-1:0]  wb_data_i;
    // EX side
    logic                   valid_ex_o;
    logic                   ready_ex_i;
    logic [DATA_WIDTH-1:0]  rs1_data_ex_o;
    logic [DATA_WIDTH-1:0]  rs2_data_ex_o;
    logic [4:0]             rs1_addr_ex_o;
    logic [4:0]             rs2_addr_ex_o;
    logic [4:0]             rd_addr_ex_o;
    logic                   rd_en_ex_o;
    logic [IMM_WIDTH-1:0]   imm_data_ex_o;
    logic [6:0]             opcode_ex_o;
    logic [2:0]             funct3_ex_o;
    logic [6:0]             funct7_ex_o;
    logic                   mem_w_en_ex_o;
    logic                   mem_r_en_ex_o;
    logic [ADDR_WIDTH-1:0]  pc_ex_o;
    logic                   illegal_ex_o;

    // Environment side: drives the instruction stream, regfile data and EX ready.
    modport master (
        output valid_id_i, instr_data_id_i, pc_id_i, flush_i,
               rs1_data_wb_i, rs2_data_wb_i, wb_en_i, wb_addr_i, wb_data_i, ready_ex_i,
        input  ready_id_o, rs1_addr_wb_o, rs2_addr_wb_o, valid_ex_o,
               rs1_data_ex_o, rs2_data_ex_o, rs1_addr_ex_o, rs2_addr_ex_o, rd_addr_ex_o,
               rd_en_ex_o, imm_data_ex_o, opcode_ex_o, funct3_ex_o, funct7_ex_o,
               mem_w_en_ex_o, mem_r_en_ex_o, pc_ex_o, illegal_ex_o
    );

    // Decode stage side.
    modport slave (
        input  valid_id_i, instr_data_id_i, pc_id_i, flush_i,
               rs1_data_wb_i, rs2_data_wb_i, wb_en_i, wb_addr_i, wb_data_i, ready_ex_i,
        output ready_id_o, rs1_addr_wb_o, rs2_addr_wb_o, valid_ex_o,
               rs1_data_ex_o, rs2_data_ex_o, rs1_addr_ex_o, rs2_addr_ex_o, rd_addr_ex_o,
               rd_en_ex_o, imm_data_ex_o, opcode_ex_o, funct3_ex_o, funct7_ex_o,
               mem_w_en_ex_o, mem_r_en_ex_o, pc_ex_o, illegal_ex_o
    );
endinterface

// File: rtl/cprv_decode_stage.sv
// RV64I decode stage: immediates, register usage, WB bypass, load-use interlock, flush.
// Latency: one cycle from IF accept to valid_ex_o.
// Backpressure: ready_id_o drops when EX holds and stalls, or on a load-use hazard; flush always accepts.
module cprv_decode_stage #(
    parameter int INSTR_WIDTH  = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 64,
    parameter int IMM_WIDTH    = 64,
    parameter bit WB_BYPASS_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    cprv_decode_stage_if.slave   bus
);

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    logic [INSTR_WIDTH-1:0] instr;
    logic [6:0]             opcode;
    logic [4:0]             rs1_addr;
    logic [4:0]             rs2_addr;
    logic [4:0]             rd_addr;
    logic                   legal;
    logic                   rs1_used;
    logic                   rs2_used;
    logic                   rd_class;
    logic                   rd_en;
    logic                   is_load;
    logic                   is_store;
    logic [IMM_WIDTH-1:0]   imm;
    logic [DATA_WIDTH-1:0]  rs1_val;
    logic [DATA_WIDTH-1:0]  rs2_val;
    logic                   hazard;
    logic                   ready;
    logic                   accept;

    assign instr    = bus.instr_data_id_i;
    assign opcode   = instr[6:0];
    assign rd_addr  = instr[11:7];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];

    assign bus.rs1_addr_wb_o = rs1_addr;
    assign bus.rs2_addr_wb_o = rs2_addr;

    // Classify the opcode and build the sign-extended immediate. Every listed
    // opcode ends in 2'b11, so a compressed-quadrant word never matches and
    // falls into the illegal default.
    always_comb begin
        legal    = 1'b0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        rd_class = 1'b0;
        imm      = '0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                legal    = 1'b1;
                rd_class = 1'b1;
                imm      = {{(IMM_WIDTH-32){instr[31]}}, instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                legal    = 1'b1;
                rd_class = 1'b1;
                imm      = {{(IMM_WIDTH-21){instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32: begin
                legal    = 1'b1;
                rd_class = 1'b1;
                rs1_used = 1'b1;
                imm      = {{(IMM_WIDTH-12){instr[31]}}, instr[31:20]};
            end
            OPC_BRANCH: begin
                legal    = 1'b1;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                imm      = {{(IMM_WIDTH-13){instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            end
            OPC_STORE: begin
                legal    = 1'b1;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                imm      = {{(IMM_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_OP, OPC_OP_32: begin
                legal    = 1'b1;
                rd_class = 1'b1;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            default: ;
        endcase
    end

    assign rd_en    = rd_class & (rd_addr != 5'd0);
    assign is_load  = (opcode == OPC_LOAD);
    assign is_store = (opcode == OPC_STORE);

    // Operand select: x0 reads as zero, otherwise same-cycle write-back wins over the regfile.
    always_comb begin
        rs1_val = bus.rs1_data_wb_i;
        rs2_val = bus.rs2_data_wb_i;
        if (WB_BYPASS_EN && bus.wb_en_i && (bus.wb_addr_i == rs1_addr)) rs1_val = bus.wb_data_i;
        if (WB_BYPASS_EN && bus.wb_en_i && (bus.wb_addr_i == rs2_addr)) rs2_val = bus.wb_data_i;
        if (rs1_addr == 5'd0) rs1_val = '0;
        if (rs2_addr == 5'd0) rs2_val = '0;
    end

    // A load sitting in EX cannot forward yet, so a dependent instruction waits one bubble.
    assign hazard = bus.valid_ex_o & bus.mem_r_en_ex_o & bus.rd_en_ex_o & bus.valid_id_i &
                    ((rs1_used & (rs1_addr == bus.rd_addr_ex_o)) |
                     (rs2_used & (rs2_addr == bus.rd_addr_ex_o)));

    assign ready          = bus.flush_i | ((~bus.valid_ex_o | bus.ready_ex_i) & ~hazard);
    assign accept         = bus.valid_id_i & ready & ~bus.flush_i;
    assign bus.ready_id_o = ready;

    // EX pipeline register: flush kills, accept loads, EX fire without accept drains, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.valid_ex_o    <= 1'b0;
            bus.rs1_data_ex_o <= '0;
            bus.rs2_data_ex_o <= '0;
            bus.rs1_addr_ex_o <= '0;
            bus.rs2_addr_ex_o <= '0;
            bus.rd_addr_ex_o  <= '0;
            bus.rd_en_ex_o    <= 1'b0;
            bus.imm_data_ex_o <= '0;
            bus.opcode_ex_o   <= '0;
            bus.funct3_ex_o   <= '0;
            bus.funct7_ex_o   <= '0;
            bus.mem_w_en_ex_o <= 1'b0;
            bus.mem_r_en_ex_o <= 1'b0;
            bus.pc_ex_o       <= '0;
            bus.illegal_ex_o  <= 1'b0;
        end else if (bus.flush_i) begin
            bus.valid_ex_o <= 1'b0;
        end else if (accept) begin
            bus.valid_ex_o    <= 1'b1;
            bus.rs1_data_ex_o <= rs1_val;
            bus.rs2_data_ex_o <= rs2_val;
            bus.rs1_addr_ex_o <= rs1_addr;
            bus.rs2_addr_ex_o <= rs2_addr;
            bus.rd_addr_ex_o  <= rd_addr;
            bus.rd_en_ex_o    <= legal & rd_en;
            bus.imm_data_ex_o <= imm;
            bus.opcode_ex_o   <= opcode;
            bus.funct3_ex_o   <= instr[14:12];
            bus.funct7_ex_o   <= instr[31:25];
            bus.mem_w_en_ex_o <= legal & is_store;
            bus.mem_r_en_ex_o <= legal & is_load;
            bus.pc_ex_o       <= bus.pc_id_i;
            bus.illegal_ex_o  <= ~legal;
        end else if (bus.ready_ex_i) begin
            bus.valid_ex_o <= 1'b0;
        end
    end

endmodule
